// File: rtl/alu_shift_pkg.sv
// Shared opcode and state definitions for the sequential shift unit and its
// single-position shift stage.
package alu_shift_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_SRL   = 2'b00;
    localparam op_t OP_SRL_A = 2'b01;
    localparam op_t OP_SLL   = 2'b10;
    localparam op_t OP_ROR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate; the sequential unit iterates it
// once per clock.
module shift_step
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    always_comb begin
        d_out = {1'b0, d_in[WIDTH-1:1]};
        case (op)
            OP_SRL:   d_out = {1'b0, d_in[WIDTH-1:1]};
            OP_SRL_A: d_out = {d_in[WIDTH-1], d_in[WIDTH-1:1]};
            OP_SLL:   d_out = {d_in[WIDTH-2:0], 1'b0};
            OP_ROR:   d_out = {d_in[0], d_in[WIDTH-1:1]};
            default:  d_out = {1'b0, d_in[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift unit: one bit position per clock under a start/busy/done
// handshake; result and zero are held until the next operation completes.
module shift_seq_unit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic [AMT_W-1:0] count_q,  count_d;
    op_t              op_q,     op_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic [WIDTH-1:0] step_out;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op    (op_q),
        .d_in  (data_q),
        .d_out (step_out)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = operand;
                    count_d = amount;
                    op_d    = op;
                    if (amount != '0) begin
                        state_d = S_SHIFT;
                    end else begin
                        // Zero-step operation completes immediately with the operand.
                        state_d  = S_DONE;
                        result_d = operand;
                        zero_d   = (operand == '0);
                    end
                end
            end
            S_SHIFT: begin
                data_d  = step_out;
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = step_out;
                    zero_d   = (step_out == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Handshake outputs are registered from the next state.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            count_q  <= '0;
            op_q     <= OP_SRL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule
